// File: rtl/slice_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : slice_scheduler_pkg
// Description : Shared display constants, slice index type and FSM encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package slice_scheduler_pkg;

    localparam int SLICES_PER_TURN = 256;
    localparam int SLICE_W         = $clog2(SLICES_PER_TURN);

    typedef logic [SLICE_W-1:0] slice_idx_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_RUN     = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/slice_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : slice_scheduler_if
// Description : Hall/frame inputs and slice outputs of the slice sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface slice_scheduler_if #(
    parameter int SLICE_W      = slice_scheduler_pkg::SLICE_W,
    parameter int PERIOD_WIDTH = 24
);
    logic                    hall_n;
    logic                    frame_loaded;
    logic                    position_sync;
    logic [SLICE_W-1:0]      slice_idx;
    logic                    stream_ready;
    logic                    locked;
    logic [PERIOD_WIDTH-1:0] turn_period;

    modport master (
        output hall_n, frame_loaded,
        input  position_sync, slice_idx, stream_ready, locked, turn_period
    );

    modport slave (
        input  hall_n, frame_loaded,
        output position_sync, slice_idx, stream_ready, locked, turn_period
    );
endinterface
`default_nettype wire

// File: rtl/slice_scheduler_hall_sync.sv
`default_nettype none
// ============================================================================
// Module      : hall_sync
// Description : Hall synchronizer, falling-edge detect, debounce, period count.
// Revision    : 1.0 - initial release
// ============================================================================
module hall_sync #(
    parameter int PERIOD_WIDTH = 24,
    parameter int MIN_PERIOD   = 33000
) (
    input  wire                     clk,
    input  wire                     rst_n,
    input  wire                     i_hall_n,
    output logic                    o_idx_evt,
    output logic [PERIOD_WIDTH-1:0] o_period_cnt
);
    logic                    r_sync1;
    logic                    r_sync2;
    logic                    r_sync2_d;
    logic [PERIOD_WIDTH-1:0] r_period_cnt;
    logic                    w_fall;
    logic                    w_accept;

    assign w_fall   = r_sync2_d & ~r_sync2;
    assign w_accept = w_fall & (r_period_cnt >= PERIOD_WIDTH'(MIN_PERIOD));

    // Counter resets saturated so the first edge after reset is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1      <= 1'b1;
            r_sync2      <= 1'b1;
            r_sync2_d    <= 1'b1;
            r_period_cnt <= '1;
        end else begin
            r_sync1   <= i_hall_n;
            r_sync2   <= r_sync1;
            r_sync2_d <= r_sync2;
            if (w_accept)
                r_period_cnt <= PERIOD_WIDTH'(1);
            else if (!(&r_period_cnt))
                r_period_cnt <= r_period_cnt + 1'b1;
        end
    end

    assign o_idx_evt    = w_accept;
    assign o_period_cnt = r_period_cnt;
endmodule
`default_nettype wire

// File: rtl/slice_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : slice_scheduler
// Description : Rotation lock FSM, turn period latch and slice timer.
// Revision    : 1.0 - initial release
// ============================================================================
module slice_scheduler #(
    parameter int SLICES_PER_TURN = slice_scheduler_pkg::SLICES_PER_TURN,
    parameter int PERIOD_WIDTH    = 24,
    parameter int MIN_PERIOD      = 33000,
    parameter int LOCK_TURNS      = 2
) (
    input  wire               clk_33,
    input  wire               nrst,
    slice_scheduler_if.slave  bus
);
    import slice_scheduler_pkg::*;

    localparam int              IDX_W      = $clog2(SLICES_PER_TURN);
    localparam int              TC_W       = $clog2(LOCK_TURNS + 1);
    localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(SLICES_PER_TURN - 1);

    state_t                  r_state,        w_state_nxt;
    logic [TC_W-1:0]         r_turn_cnt,     w_turn_cnt_nxt;
    logic                    r_locked,       w_locked_nxt;
    logic                    r_sync,         w_sync_nxt;
    logic [IDX_W-1:0]        r_idx,          w_idx_nxt;
    logic [PERIOD_WIDTH-1:0] r_timer,        w_timer_nxt;
    logic [PERIOD_WIDTH-1:0] r_slice_period, w_slice_period_nxt;
    logic [PERIOD_WIDTH-1:0] r_turn_period,  w_turn_period_nxt;
    logic                    r_stream_ready;

    logic                    w_idx_evt;
    logic [PERIOD_WIDTH-1:0] w_period_cnt;
    logic [PERIOD_WIDTH-1:0] w_shift;
    logic [PERIOD_WIDTH-1:0] w_new_sp;
    logic                    w_timeout;
    logic                    w_lock_reached;

    hall_sync #(
        .PERIOD_WIDTH (PERIOD_WIDTH),
        .MIN_PERIOD   (MIN_PERIOD)
    ) u_hall_sync (
        .clk          (clk_33),
        .rst_n        (nrst),
        .i_hall_n     (bus.hall_n),
        .o_idx_evt    (w_idx_evt),
        .o_period_cnt (w_period_cnt)
    );

    // A turn shorter than one cycle per slice still advances one slice per cycle.
    assign w_shift        = w_period_cnt >> IDX_W;
    assign w_new_sp       = (w_shift == '0) ? PERIOD_WIDTH'(1) : w_shift;
    assign w_timeout      = &w_period_cnt;
    assign w_lock_reached = (r_turn_cnt + 1'b1) >= TC_W'(LOCK_TURNS);

    always_comb begin
        w_state_nxt        = r_state;
        w_turn_cnt_nxt     = r_turn_cnt;
        w_locked_nxt       = r_locked;
        w_sync_nxt         = 1'b0;
        w_idx_nxt          = r_idx;
        w_timer_nxt        = r_timer;
        w_slice_period_nxt = r_slice_period;
        w_turn_period_nxt  = r_turn_period;
        case (r_state)
            ST_IDLE: begin
                if (w_idx_evt) begin
                    w_state_nxt    = ST_MEASURE;
                    w_turn_cnt_nxt = '0;
                end
            end
            ST_MEASURE: begin
                if (w_idx_evt) begin
                    w_turn_period_nxt  = w_period_cnt;
                    w_slice_period_nxt = w_new_sp;
                    if (w_lock_reached) begin
                        w_state_nxt    = ST_RUN;
                        w_locked_nxt   = 1'b1;
                        w_turn_cnt_nxt = '0;
                        w_sync_nxt     = 1'b1;
                        w_idx_nxt      = '0;
                        w_timer_nxt    = w_new_sp - 1'b1;
                    end else begin
                        w_turn_cnt_nxt = r_turn_cnt + 1'b1;
                    end
                end else if (w_timeout) begin
                    w_state_nxt    = ST_IDLE;
                    w_turn_cnt_nxt = '0;
                end
            end
            ST_RUN: begin
                // Index edge outranks a coincident timer expiry.
                if (w_idx_evt) begin
                    w_turn_period_nxt  = w_period_cnt;
                    w_slice_period_nxt = w_new_sp;
                    w_sync_nxt         = 1'b1;
                    w_idx_nxt          = '0;
                    w_timer_nxt        = w_new_sp - 1'b1;
                end else if (w_timeout) begin
                    w_state_nxt    = ST_IDLE;
                    w_locked_nxt   = 1'b0;
                    w_turn_cnt_nxt = '0;
                    w_idx_nxt      = '0;
                end else if (r_timer == '0) begin
                    if (r_idx != C_LAST_IDX) begin
                        w_idx_nxt   = r_idx + 1'b1;
                        w_sync_nxt  = 1'b1;
                        w_timer_nxt = r_slice_period - 1'b1;
                    end
                end else begin
                    w_timer_nxt = r_timer - 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_33 or negedge nrst) begin
        if (!nrst) begin
            r_state        <= ST_IDLE;
            r_turn_cnt     <= '0;
            r_locked       <= 1'b0;
            r_sync         <= 1'b0;
            r_idx          <= '0;
            r_timer        <= '0;
            r_slice_period <= PERIOD_WIDTH'(1);
            r_turn_period  <= '0;
            r_stream_ready <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_turn_cnt     <= w_turn_cnt_nxt;
            r_locked       <= w_locked_nxt;
            r_sync         <= w_sync_nxt;
            r_idx          <= w_idx_nxt;
            r_timer        <= w_timer_nxt;
            r_slice_period <= w_slice_period_nxt;
            r_turn_period  <= w_turn_period_nxt;
            r_stream_ready <= r_locked & bus.frame_loaded;
        end
    end

    assign bus.position_sync = r_sync;
    assign bus.slice_idx     = r_idx;
    assign bus.stream_ready  = r_stream_ready;
    assign bus.locked        = r_locked;
    assign bus.turn_period   = r_turn_period;
endmodule
`default_nettype wire

// File: tb/tb_slice_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_slice_scheduler
// Description : Directed bench with a slice-pulse scoreboard (scaled periods).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_slice_scheduler;
    import slice_scheduler_pkg::*;

    localparam int     SPT   = 256;
    localparam int     PW    = 13;
    localparam int     MINP  = 200;
    localparam int     LOCKT = 2;
    localparam longint NEVER = 64'd1 << 40;

    typedef struct packed {
        logic [31:0] idx;
        logic [63:0] t;
    } exp_t;

    logic   clk_33 = 1'b0;
    logic   nrst;
    longint cyc    = 0;
    int     n_chk  = 0;
    int     n_fail = 0;
    int     n_sync = 0;
    exp_t   sb[$];

    always #15 clk_33 = ~clk_33;

    slice_scheduler_if #(.SLICE_W(SLICE_W), .PERIOD_WIDTH(PW)) bus ();

    slice_scheduler #(
        .SLICES_PER_TURN (SPT),
        .PERIOD_WIDTH    (PW),
        .MIN_PERIOD      (MINP),
        .LOCK_TURNS      (LOCKT)
    ) dut (
        .clk_33 (clk_33),
        .nrst   (nrst),
        .bus    (bus.slave)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Expected pulses of one turn: slice n at t0 + n*sp, cut off by the next index pulse.
    task automatic push_turn(input longint t0, input int sp, input longint t_next);
        exp_t e;
        for (int n = 0; n < SPT; n++) begin
            if (t0 + longint'(n) * sp >= t_next) break;
            e.idx = 32'(n);
            e.t   = 64'(t0 + longint'(n) * sp);
            sb.push_back(e);
        end
    endtask

    task automatic goto(input longint t);
        while (cyc < t) @(negedge clk_33);
    endtask

    task automatic hall_fall(output longint c);
        bus.hall_n = 1'b0;
        c = cyc;
        repeat (2) @(negedge clk_33);
        bus.hall_n = 1'b1;
    endtask

    always @(posedge clk_33) begin
        exp_t e;
        cyc = cyc + 1;
        #1;
        if (bus.position_sync === 1'b1) begin
            n_sync++;
            n_chk++;
            assert (sb.size() != 0) else begin
                n_fail++;
                $error("FAIL sync_unexpected: observed pulse idx=%0d at cycle %0d, expected no pulse",
                       bus.slice_idx, cyc);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("sync_idx", 64'(bus.slice_idx), 64'(e.idx));
                check("sync_time", 64'(cyc), e.t);
            end
        end
    end

    initial begin
        longint d1, d2, d3, d4, d5, d6, d7, d8, dg;
        nrst             = 1'b0;
        bus.hall_n       = 1'b1;
        bus.frame_loaded = 1'b0;
        repeat (3) @(negedge clk_33);
        check("rst_locked", 64'(bus.locked), 0);
        check("rst_sync", 64'(bus.position_sync), 0);
        check("rst_turn_period", 64'(bus.turn_period), 0);
        nrst = 1'b1;
        goto(cyc + 3000);
        check("idle_no_sync", 64'(n_sync), 0);
        check("idle_slice_idx", 64'(bus.slice_idx), 0);
        check("idle_stream_ready", 64'(bus.stream_ready), 0);

        // Acquire lock at 2048 cycles/turn: slice period 8.
        bus.frame_loaded = 1'b1;
        hall_fall(d1);
        goto(d1 + 2048);
        hall_fall(d2);
        goto(d2 + 3);
        check("measure_not_locked", 64'(bus.locked), 0);
        check("measure_turn_period", 64'(bus.turn_period), 2048);
        check("measure_stream_ready", 64'(bus.stream_ready), 0);
        goto(d2 + 2048);
        push_turn(cyc + 3, 8, cyc + 2048 + 3);
        hall_fall(d3);
        goto(d3 + 2);
        check("lock_before_pulse", 64'(bus.locked), 0);
        goto(d3 + 3);
        check("lock_with_slice0", 64'(bus.locked), 1);
        check("ready_lags_lock", 64'(bus.stream_ready), 0);
        goto(d3 + 4);
        check("ready_after_lock", 64'(bus.stream_ready), 1);

        // Turn shortened to 1600 with a glitch and a frame_loaded drop inside it.
        goto(d3 + 2048);
        push_turn(cyc + 3, 8, cyc + 1600 + 3);
        hall_fall(d4);
        goto(d4 + 50);
        hall_fall(dg);
        goto(d4 + 60);
        check("glitch_turn_period", 64'(bus.turn_period), 2048);
        goto(d4 + 100);
        bus.frame_loaded = 1'b0;
        check("ready_before_drop", 64'(bus.stream_ready), 1);
        goto(d4 + 101);
        check("ready_dropped", 64'(bus.stream_ready), 0);
        check("locked_on_drop", 64'(bus.locked), 1);
        goto(d4 + 200);
        bus.frame_loaded = 1'b1;
        goto(d4 + 201);
        check("ready_restored", 64'(bus.stream_ready), 1);

        goto(d4 + 1600);
        push_turn(cyc + 3, 6, cyc + 1600 + 3);
        hall_fall(d5);
        goto(d5 + 3);
        check("short_turn_period", 64'(bus.turn_period), 1600);
        goto(d5 + 1600);
        push_turn(cyc + 3, 6, cyc + 220 + 3);
        hall_fall(d6);
        goto(d6 + 220);
        push_turn(cyc + 3, 1, cyc + 220 + 3);
        hall_fall(d7);
        goto(d7 + 3);
        check("tiny_turn_period", 64'(bus.turn_period), 220);
        goto(d7 + 220);
        push_turn(cyc + 3, 1, NEVER);
        hall_fall(d8);

        // Hall stops: hold last slice, then saturate and drop lock.
        goto(d8 + 3 + 300);
        check("slow_hold_idx", 64'(bus.slice_idx), 255);
        check("slow_all_pulses", 64'(sb.size()), 0);
        goto(d8 + 3 + 8190);
        check("pre_timeout_locked", 64'(bus.locked), 1);
        goto(d8 + 3 + 8191);
        check("timeout_unlocked", 64'(bus.locked), 0);
        goto(d8 + 3 + 8192);
        check("timeout_not_ready", 64'(bus.stream_ready), 0);

        // Relock, then reset at slice 100.
        hall_fall(d1);
        goto(d1 + 2048);
        hall_fall(d2);
        goto(d2 + 2048);
        push_turn(cyc + 3, 8, NEVER);
        hall_fall(d3);
        goto(d3 + 3 + 800);
        check("pre_reset_idx", 64'(bus.slice_idx), 100);
        nrst = 1'b0;
        #1;
        check("async_rst_locked", 64'(bus.locked), 0);
        check("async_rst_idx", 64'(bus.slice_idx), 0);
        check("async_rst_ready", 64'(bus.stream_ready), 0);
        check("async_rst_turn_period", 64'(bus.turn_period), 0);
        sb.delete();
        @(negedge clk_33);
        nrst = 1'b1;
        @(negedge clk_33);
        hall_fall(d1);
        goto(d1 + 2048);
        hall_fall(d2);
        goto(d2 + 3);
        check("relock_not_early", 64'(bus.locked), 0);
        goto(d2 + 2048);
        push_turn(cyc + 3, 8, NEVER);
        hall_fall(d3);
        goto(d3 + 3);
        check("relock_locked", 64'(bus.locked), 1);
        goto(d3 + 3 + 2100);
        check("relock_all_pulses", 64'(sb.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
